// File: rtl/spram_fifo_arbiter.sv
// rtl/spram_fifo_arbiter.sv - single-port SPRAM sequencer for the UART byte FIFO
//
// Serializes RX byte writes and paced TX reads onto one SPRAM port, at most one
// access per cycle, and owns the FIFO pointers, occupancy and status flags.
// Writes go through a one-entry holding register and always win over reads.
//
// Optional feature macro: SPRAM_FIFO_PACING_EN
//   defined   - a read may only start on pace_tick (counter wraps every PACE_DIV clks)
//   undefined - no pace counter; reads start whenever the FIFO is idle and has data
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   wr_data, wr_strobe  byte from RX with one-cycle write request
//   rd_ready            consumer can accept a byte
//   rd_data, rd_strobe  byte read from FIFO, one-cycle valid pulse
//   data_available      count != 0
//   full                count == 2**ADDR_W
//   count               occupancy
//   overflow            sticky, a byte was dropped
//   ram_addr, ram_wdata, ram_maskwren, ram_wren, ram_rdata  SPRAM port

module spram_fifo_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int PACE_DIV = 524288
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        wr_data,
    input  logic              wr_strobe,
    input  logic              rd_ready,
    output logic [7:0]        rd_data,
    output logic              rd_strobe,
    output logic              data_available,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic [3:0]        ram_maskwren,
    output logic              ram_wren,
    input  logic [15:0]       ram_rdata
);

    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_ADDR = 2'd2,
        RD_CAP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              hold_valid;
    logic [7:0]        hold_data;
    logic [7:0]        rd_data_q;
    logic              rd_strobe_q;
    logic              overflow_q;
    logic              pace_tick;
    logic              hold_drain;

    // Only the low byte of each SPRAM word carries FIFO data.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^ram_rdata[15:8];

`ifdef SPRAM_FIFO_PACING_EN
    localparam int PACE_W = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;

    logic [PACE_W-1:0] pace_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            pace_cnt <= '0;
        end else if (pace_cnt == PACE_W'(PACE_DIV - 1)) begin
            pace_cnt <= '0;
        end else begin
            pace_cnt <= pace_cnt + PACE_W'(1);
        end
    end

    assign pace_tick = (pace_cnt == '0);
`else
    // PACE_DIV has no effect when pacing is compiled out.
    localparam int unused_pace_div = PACE_DIV;

    assign pace_tick = 1'b1;
`endif

    assign full           = (count_q == DEPTH_CNT);
    assign data_available = (count_q != '0);
    assign count          = count_q;
    assign rd_data        = rd_data_q;
    assign rd_strobe      = rd_strobe_q;
    assign overflow       = overflow_q;
    assign hold_drain     = (state == WRITE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a pending write always beats a read. A read is not
    // started while the previous byte's strobe is still showing, so the
    // consumer gets a cycle to drop rd_ready.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    state_next = WRITE;
                end else if (data_available && rd_ready && pace_tick && !rd_strobe_q) begin
                    state_next = RD_ADDR;
                end
            end
            WRITE:   state_next = IDLE;
            RD_ADDR: state_next = RD_CAP;
            RD_CAP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: the address is driven live in the access cycle so the
    // SPRAM samples it at the end of that cycle; otherwise the last used
    // address is held.
    always_comb begin
        ram_addr     = addr_q;
        ram_wren     = 1'b0;
        ram_wdata    = {8'h00, hold_data};
        ram_maskwren = 4'b0011;
        case (state)
            WRITE: begin
                ram_addr = wptr;
                ram_wren = !full;
            end
            RD_ADDR: begin
                ram_addr = rptr;
            end
            default: ;
        endcase
    end

    // Datapath: pointers, count, holding register, read capture, flags.
    // Only WRITE changes count upward and only RD_ADDR downward, and they are
    // distinct states, so count never has two sources in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            hold_valid  <= 1'b0;
            hold_data   <= 8'h00;
            rd_data_q   <= 8'h00;
            rd_strobe_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rd_strobe_q <= (state == RD_CAP);
            if (state == RD_CAP) begin
                rd_data_q <= ram_rdata[7:0];
            end

            // A strobe landing on the drain cycle refills the hold directly.
            if (wr_strobe && (!hold_valid || hold_drain)) begin
                hold_valid <= 1'b1;
                hold_data  <= wr_data;
            end else if (hold_drain) begin
                hold_valid <= 1'b0;
            end

            if (wr_strobe && hold_valid && !hold_drain) begin
                overflow_q <= 1'b1;
            end

            if (state == WRITE) begin
                addr_q <= wptr;
                if (full) begin
                    overflow_q <= 1'b1;
                end else begin
                    wptr    <= wptr + ADDR_W'(1);
                    count_q <= count_q + (ADDR_W + 1)'(1);
                end
            end

            if (state == RD_ADDR) begin
                addr_q  <= rptr;
                rptr    <= rptr + ADDR_W'(1);
                count_q <= count_q - (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: doc/spram_fifo_arbiter.md
Name: spram_fifo_arbiter

Overview:
Sequencer for the single-port SPRAM behind the UART byte FIFO. It accepts byte writes from the RX path and paced read requests from the TX path. It serializes both onto the one SPRAM port, with at most one access per cycle, and owns the FIFO pointers, the occupancy count and the full, empty and overflow status. It sits between uart_rx/uart_tx and the SB_SPRAM256KA primitive, replacing ad-hoc "don't read on a write cycle" gating in top.

Parameters:
ADDR_W, 14, SPRAM word address width; FIFO depth = 2**ADDR_W words, one byte per word
PACE_DIV, 524288, read pacing period in clk cycles; 1 = no pacing gap

Ports:
clk  in  1  system clock (48 MHz)
reset  in  1  synchronous, active-high reset
wr_data  in  8  byte from RX
wr_strobe  in  1  one-cycle write request
rd_ready  in  1  consumer (uart_tx) can accept a byte
rd_data  out  8  byte read from FIFO
rd_strobe  out  1  one-cycle pulse, rd_data valid
data_available  out  1  count != 0
full  out  1  count == 2**ADDR_W
count  out  ADDR_W+1  occupancy
overflow  out  1  sticky, a byte was dropped
ram_addr  out  ADDR_W  SPRAM address
ram_wdata  out  16  SPRAM write data = {8'h00, byte}
ram_maskwren  out  4  constant 4'b0011
ram_wren  out  1  SPRAM write enable
ram_rdata  in  16  SPRAM read data, valid 1 cycle after a read address is presented

Behaviour:
- Reset, all synchronous, all outputs: pointers=0, count=0, rd_data=0, rd_strobe=0, overflow=0, ram_wren=0, ram_addr=0, hold_valid=0, pace counter=0, state=IDLE.
- Write holding register (1 entry): wr_strobe with hold_valid=0 loads the byte and sets hold_valid.
  - wr_strobe with hold_valid=1 and the hold not draining this cycle: byte dropped, overflow<=1.
  - wr_strobe in the cycle the hold drains: the new byte is accepted into the hold.
- Pace counter: free-running 0..PACE_DIV-1, wraps to 0. pace_tick = (counter==0).
- FSM states: IDLE, WRITE, RD_ADDR, RD_CAP.
  - IDLE: if hold_valid, go to WRITE. This is write priority.
  - IDLE: else if data_available && rd_ready && pace_tick && no rd_strobe last cycle, go to RD_ADDR.
  - WRITE (1 cycle): ram_addr=wptr, ram_wren=1.
    - If full: nothing is written and overflow<=1.
    - Otherwise: wptr++ (wraps mod 2**ADDR_W) and count++.
    - Clears hold_valid either way. Next state IDLE.
  - RD_ADDR (1 cycle): ram_addr=rptr, ram_wren=0, rptr++ (wraps), count--. Next state RD_CAP.
  - RD_CAP (1 cycle): rd_data<=ram_rdata[7:0], rd_strobe<=1 (visible the next cycle). Next state IDLE.
- Read latency: pace_tick in IDLE at cycle N, RD_ADDR at N+1, rd_strobe high at N+3 for exactly one cycle.
- Writes arriving during RD_ADDR or RD_CAP wait in the hold. Maximum wait is 2 cycles before WRITE.
- ram_wren is 1 only in WRITE (when not full). ram_addr holds its last value in IDLE.
- Simultaneous write and read completion in the same cycle cannot occur; all count updates are single-source.
- full/data_available are combinational from count. Count never exceeds 2**ADDR_W and never underflows.
- Reset mid-read: any in-flight read is discarded, no rd_strobe. Reset mid-write: the hold byte is lost.

Optional Feature:
SPRAM_FIFO_PACING_EN
- Defined: reads require pace_tick as above.
- Undefined: the pace counter is removed, pace_tick is treated as 1, and reads issue whenever IDLE && data_available && rd_ready && no hold_valid. PACE_DIV is ignored.

Test Plan:
1. Reset, then write 3 bytes 0x41,0x42,0x43 spaced 10 cycles apart, ADDR_W=4, PACE_DIV=8 -> count=3; rd_strobe later yields 0x41,0x42,0x43 in order, each with rd_strobe one cycle; count returns to 0.
2. Fill to 16 with ADDR_W=4, then write 0x99 -> full=1, count stays 16, overflow=1, 0x99 never read back.
3. wr_strobe on two consecutive cycles while the FSM is in RD_ADDR -> first byte held, second dropped, overflow=1; the held byte is written within 2 cycles.
4. Write 20 bytes and read 20 bytes across the pointer wrap (ADDR_W=4) -> bytes read in exact order, no loss.
5. With rd_ready=0 and count=5 -> no RD_ADDR, no rd_strobe. rd_ready=1 -> first rd_strobe exactly 3 cycles after the next pace_tick.
6. Assert reset while in RD_CAP -> next cycle rd_strobe=0, count=0, overflow=0, ram_wren=0.
